golomb_encoder: RTL and testbench
=================================

GOLOMB_ENCODER -- requirements
Module: golomb_encoder

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 n_in  in  9  sample to encode; legal range 0..256.
REQ-005 m_in  in  3  Rice parameter, with divisor 2^m_in; sampled with n_in.
REQ-006 valid_in  in  1  n_in/m_in valid.
REQ-007 ready_out  out  1  block accepts a sample this cycle.
REQ-008 flush  in  1  single-cycle request to drain and pad the stream.
REQ-009 word_out  out  32  packed bitstream word, MSB = earliest bit.
REQ-010 word_valid  out  1  word_out valid.
REQ-011 word_ready  in  1  downstream decoder ready (high when its buffer holds 32 bits or fewer).
REQ-012 flush_done  out  1  one-cycle pulse when the flush is complete.

Function
REQ-013 Code generation: q = n_in >> m_in, r = n_in[m_in-1:0].
REQ-014 If q < 23, the code SHALL be q '0' bits, then one '1' bit, then the m_in bits of r (MSB first), with len = q+1+m_in (maximum 30).
REQ-015 If q >= 23, the code SHALL be 23 '0' bits, then one '1' bit, then the 8 bits of (n_in-1) (escape code), with len = 32.
REQ-016 n_in > 256 is illegal input; output is don't-care, but internal state SHALL NOT corrupt.
REQ-017 Stage 1 is a code register (32-bit code right-aligned, 6-bit len, valid); a sample is accepted when valid_in && ready_out.
REQ-018 Stage 2 is a 64-bit left-aligned pack buffer plus a 7-bit fill count, 0..64.
REQ-019 A word pop occurs when word_valid && word_ready, and SHALL shift the buffer left by 32 and reduce fill by 32.
REQ-020 word_valid SHALL be 1 when fill >= 32, or when the flush pad is pending; word_out = buf[63:32].
REQ-021 Append: the stage-1 code SHALL move into the buffer when fill_after_pop + len <= 64, where fill_after_pop is fill minus 32 if a pop occurs this cycle, else fill.
REQ-022 On append, the code SHALL be placed at bit position 63 - fill_after_pop downward, and fill_after_pop + len SHALL become the new fill.
REQ-023 A pop and an append in the same cycle SHALL both take effect.
REQ-024 ready_out = !stage1_valid || stage1_moves_this_cycle, and SHALL be 0 in the FLUSH state.
REQ-025 Latency: a sample accepted at edge t SHALL enter stage 1 at t+1 and the buffer at t+2 (absent backpressure); word_valid may rise in the cycle after t+2.
REQ-026 The FSM SHALL have states RUN, FLUSH, PAD and DONE.
REQ-027 RUN -> FLUSH on flush=1; a sample presented in that same cycle SHALL still be accepted.
REQ-028 FLUSH: wait until stage 1 is empty and fill < 32; then go to DONE if fill == 0, else go to PAD.
REQ-029 PAD: set fill to 32 (the low bits are already zero); hold word_valid until popped, then go to DONE.
REQ-030 DONE: flush_done = 1 for one cycle, then return to RUN with fill = 0.
REQ-031 flush asserted outside RUN SHALL be ignored.
REQ-032 Unused buffer bits SHALL always be 0, so padding is zeros.
REQ-033 While word_ready=0 the buffer SHALL hold at most 64 bits; no code SHALL be lost or reordered under any backpressure pattern.

Reset
REQ-034 While rst=1, the block SHALL clear stage1_valid, buffer and fill, and set state = RUN.
REQ-035 Output reset values SHALL be: ready_out=1 (combinational), word_out=0, word_valid=0, flush_done=0.
REQ-036 Reset asserted mid-operation or mid-flush SHALL discard all pending bits with no partial word emitted.

Verification
REQ-037 m=2, n=9 (code "00101"), then flush -> one word 0x28000000, then a flush_done pulse.
REQ-038 m=0, n=30 (escape code) -> word 0x0000011D, with word_valid in the cycle after the buffer is written.
REQ-039 Four samples m=7, n=255 (9 bits each), then flush -> words 0x7FBFDFEF and 0xF0000000, then flush_done.
REQ-040 word_ready=0 with back-to-back escape codes -> ready_out drops once stage 1 is full and the buffer is at 64; releasing word_ready yields every word in order.
REQ-041 m=0, n=0 repeated 32 times -> word 0xFFFFFFFF, with fill returning to 0.
REQ-042 rst pulsed during PAD -> word_valid=0 and flush_done=0 next cycle; a subsequent m=2, n=9 plus flush again yields 0x28000000.

Source files
------------

// File: rtl/golomb_encoder.sv
// Rice/Golomb encoder: codes each sample into stage 1, packs codes MSB-first
// into a 64-bit buffer and emits 32-bit words; flush pads the tail with zeros.
module golomb_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  n_in,
  input  logic [2:0]  m_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        flush,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        flush_done
);

  typedef enum logic [1:0] {RUN, FLUSH, PAD, DONE} state_t;

  state_t      state_q, state_d;
  logic        s1_vld_q, s1_vld_d;
  logic [31:0] s1_code_q;
  logic [5:0]  s1_len_q;
  logic [63:0] buf_q, buf_d;
  logic [6:0]  fill_q, fill_d;

  logic [31:0] code_c;
  logic [5:0]  len_c;
  logic [8:0]  quot_c;
  logic [8:0]  rmask_c;
  logic [7:0]  nm1_c;
  logic        accept, pop, append;
  logic [6:0]  fill_ap;
  logic [7:0]  fill_sum;
  logic [63:0] aligned, placed;

  // Code generation; the code value never has bits set above its length.
  always_comb begin
    quot_c  = n_in >> m_in;
    rmask_c = (9'd1 << m_in) - 9'd1;
    nm1_c   = n_in[7:0] - 8'd1;
    code_c  = '0;
    len_c   = '0;
    if (quot_c < 9'd23) begin
      code_c = {23'd0, (9'd1 << m_in) | (n_in & rmask_c)};
      len_c  = quot_c[5:0] + 6'd1 + {3'd0, m_in};
    end else begin
      code_c = {23'd0, 1'b1, nm1_c};
      len_c  = 6'd32;
    end
  end

  assign word_valid = (fill_q >= 7'd32) || (state_q == PAD);
  assign word_out   = buf_q[63:32];
  assign flush_done = (state_q == DONE);
  assign pop        = word_valid && word_ready;
  assign fill_ap    = pop ? (fill_q - 7'd32) : fill_q;
  assign fill_sum   = {1'b0, fill_ap} + {2'b00, s1_len_q};
  assign append     = s1_vld_q && (fill_sum <= 8'd64) && (state_q != PAD);
  assign ready_out  = ((state_q == RUN) || (state_q == DONE)) && (!s1_vld_q || append);
  assign accept     = valid_in && ready_out;

  // Left-justify the code to bit 63, then slide it down behind the live bits.
  assign aligned = {s1_code_q, 32'd0} << (6'd32 - s1_len_q);
  assign placed  = aligned >> fill_ap;

  always_comb begin
    state_d  = state_q;
    s1_vld_d = s1_vld_q;
    buf_d    = buf_q;
    fill_d   = fill_ap;
    if (pop) begin
      buf_d = buf_q << 32;
    end
    if (append) begin
      buf_d  = buf_d | placed;
      fill_d = fill_sum[6:0];
    end
    if (accept) begin
      s1_vld_d = 1'b1;
    end else if (append) begin
      s1_vld_d = 1'b0;
    end
    case (state_q)
      RUN: begin
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (!s1_vld_q && (fill_q < 7'd32)) begin
          if (fill_q == 7'd0) begin
            state_d = DONE;
          end else begin
            state_d = PAD;
            fill_d  = 7'd32;
          end
        end
      end
      PAD: begin
        if (pop) state_d = DONE;
      end
      DONE: begin
        state_d = RUN;
        fill_d  = '0;
        buf_d   = '0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      s1_vld_q <= 1'b0;
      buf_q    <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      s1_vld_q <= s1_vld_d;
      buf_q    <= buf_d;
      fill_q   <= fill_d;
    end
  end

  // Stage-1 payload is qualified by s1_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_code_q <= code_c;
      s1_len_q  <= len_c;
    end
  end

endmodule

// File: tb/tb_golomb_encoder.sv
// Scoreboard bench for golomb_encoder: a bit-queue reference model predicts
// every output word; a monitor compares whatever the encoder emits.
module tb_golomb_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  n_in = '0;
  logic [2:0]  m_in = '0;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic        word_ready = 1'b1;
  logic        ready_out, word_valid, flush_done;
  logic [31:0] word_out;

  int checks = 0;
  int failures = 0;
  bit          bitq[$];
  logic [31:0] expq[$];
  int flush_issued = 0;
  int flush_seen = 0;
  bit rand_ready = 1'b0;

  golomb_encoder dut (
    .clk(clk), .rst(rst), .n_in(n_in), .m_in(m_in), .valid_in(valid_in),
    .ready_out(ready_out), .flush(flush), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic void pack_words();
    logic [31:0] w;
    while (bitq.size() >= 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w = {w[30:0], bitq.pop_front()};
      expq.push_back(w);
    end
  endfunction

  // Code = q zeros, a one, then m remainder bits; escape for large quotients.
  function automatic void model_sample(input int n, input int m);
    int q = n >> m;
    if (q < 23) begin
      repeat (q) bitq.push_back(1'b0);
      bitq.push_back(1'b1);
      for (int i = m - 1; i >= 0; i--) bitq.push_back(((n >> i) & 1) != 0);
    end else begin
      repeat (23) bitq.push_back(1'b0);
      bitq.push_back(1'b1);
      for (int i = 7; i >= 0; i--) bitq.push_back((((n - 1) >> i) & 1) != 0);
    end
    pack_words();
  endfunction

  function automatic void model_flush();
    if (bitq.size() > 0) begin
      while (bitq.size() < 32) bitq.push_back(1'b0);
      pack_words();
    end
  endfunction

  // Monitor: every accepted word must be the next predicted one.
  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid && word_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %h, want none", word_out);
        end else begin
          check("word", word_out, expq.pop_front());
        end
      end
      if (flush_done) begin
        flush_seen++;
        check("flush_done_after_last_word", 32'(expq.size()), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) word_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int n, input int m, input bit fl);
    int waited = 0;
    n_in = 9'(n);
    m_in = 3'(m);
    valid_in = 1'b1;
    @(negedge clk);
    while (!ready_out) begin
      if (waited > 500) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: ready_out got 0, want 1");
        valid_in = 1'b0;
        return;
      end
      waited++;
      tick();
      @(negedge clk);
    end
    flush = fl;
    model_sample(n, m);
    if (fl) begin
      model_flush();
      flush_issued++;
    end
    tick();
    valid_in = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    model_flush();
    flush_issued++;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (expq.size() != 0 && k < 2000) begin
      tick();
      k++;
    end
    check(name, 32'(expq.size()), 32'd0);
  endtask

  task automatic wait_flush(input string name);
    int k = 0;
    while (flush_seen != flush_issued && k < 2000) begin
      tick();
      k++;
    end
    check(name, 32'(flush_seen), 32'(flush_issued));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready_out", 32'(ready_out), 32'd1);
    check("reset_word_valid", 32'(word_valid), 32'd0);
    check("reset_word_out", word_out, 32'd0);
    check("reset_flush_done", 32'(flush_done), 32'd0);
    tick();

    // m=2 n=9 then flush
    send(9, 2, 1'b0);
    do_flush();
    wait_flush("flush_short_code");

    // escape code and its word_valid latency
    send(30, 0, 1'b0);
    @(negedge clk);
    check("escape_wv_before_buffer", 32'(word_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("escape_wv_after_buffer", 32'(word_valid), 32'd1);
    tick();
    wait_drain("escape_drain");

    // four 9-bit codes straddling a word boundary
    repeat (4) send(255, 7, 1'b0);
    do_flush();
    wait_flush("flush_straddle");

    // 32 one-bit codes
    repeat (32) send(0, 0, 1'b0);
    wait_drain("ones_drain");
    do_flush();
    wait_flush("flush_empty");

    // backpressure with back-to-back escapes
    word_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(23 + i * 50, 0, 1'b0);
    tick();
    @(negedge clk);
    check("bp_ready_low", 32'(ready_out), 32'd0);
    check("bp_word_valid", 32'(word_valid), 32'd1);
    tick();
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(200 + i * 20, 0, 1'b0);
    wait_drain("bp_drain");

    // randomized traffic with random downstream readiness
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int n = $urandom_range(0, 256);
      int m = $urandom_range(0, 7);
      bit fl = ($urandom_range(0, 29) == 0);
      send(n, m, fl);
      if (fl) wait_flush("rand_flush");
    end
    rand_ready = 1'b0;
    word_ready = 1'b1;
    do_flush();
    wait_flush("rand_final_flush");
    wait_drain("rand_drain");

    // reset while the pad word is pending
    word_ready = 1'b0;
    send(9, 2, 1'b1);
    repeat (6) tick();
    @(negedge clk);
    check("pad_pending", 32'(word_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    bitq.delete();
    flush_issued = flush_seen;
    @(negedge clk);
    check("rst_pad_word_valid", 32'(word_valid), 32'd0);
    check("rst_pad_flush_done", 32'(flush_done), 32'd0);
    check("rst_pad_ready_out", 32'(ready_out), 32'd1);
    tick();
    word_ready = 1'b1;
    send(9, 2, 1'b1);
    wait_flush("post_reset_flush");
    wait_drain("post_reset_drain");

    repeat (5) tick();
    check("final_flush_count", 32'(flush_seen), 32'(flush_issued));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
